sha256_stream_padder: RTL

- Streaming SHA-256 message padder. Accepts a byte stream of any length over a valid/ready handshake.
- Appends the 0x80 marker, zero fill and the big-endian 64-bit bit-length field.
- Emits each padded 512-bit block as 16 big-endian 32-bit words over a second valid/ready handshake.
- Successor to the fixed one/two-block padder. Supports unbounded block count, parametrised length-counter width and backpressure, and feeds the message-schedule/compression core directly.

---
 rtl/sha256_stream_padder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_stream_padder.sv
// Streaming SHA-256 padder: bytes in, padded 512-bit blocks out as 16 big-endian words.
// Optional per-message block counter output enabled by defining SHA256_PADDER_BLKCNT_EN.
module sha256_stream_padder #(
    parameter int LEN_W = 32
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    parameter int BLK_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_keep,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_idx,
    output logic             out_blk_last,
`ifdef SHA256_PADDER_BLKCNT_EN
    output logic [BLK_W-1:0] blk_cnt,
`endif
    output logic             len_ovf
);

    typedef enum logic [2:0] {S_FILL, S_PAD, S_ZERO, S_LEN, S_EMIT} state_t;

    state_t           r_state;
    logic [5:0]       r_ptr;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_buf [64];
    logic             r_final;
    logic             r_pend_pad;
    logic             r_pend_zero;
    logic             r_extra;
    logic             r_in_msg;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [3:0]       r_idx;
    logic             r_blk_last;
    logic             r_len_ovf;
`ifdef SHA256_PADDER_BLKCNT_EN
    logic [BLK_W-1:0] r_blk_cnt;
`endif

    logic             w_we;
    logic [7:0]       w_wbyte;
    logic [63:0]      w_bitlen;
    logic [7:0]       w_len_byte;
    logic [3:0]       w_widx;
    logic [31:0]      w_word;
    logic             w_ovf_base;

    assign w_bitlen   = 64'({r_cnt, 3'b000});
    assign w_len_byte = 8'(w_bitlen >> {~r_ptr[2:0], 3'b000});
    // Next word to present: current index on the first beat, then the one after.
    assign w_widx     = r_out_valid ? r_idx + 4'd1 : r_idx;
    assign w_word     = {r_buf[{w_widx, 2'b00}], r_buf[{w_widx, 2'b01}],
                         r_buf[{w_widx, 2'b10}], r_buf[{w_widx, 2'b11}]};
    assign w_ovf_base = r_in_msg ? r_len_ovf : 1'b0;

    always_comb begin
        w_we    = 1'b0;
        w_wbyte = 8'h00;
        case (r_state)
            S_FILL: begin
                w_we    = in_valid && in_keep;
                w_wbyte = in_data;
            end
            S_PAD: begin
                w_we    = 1'b1;
                w_wbyte = 8'h80;
            end
            S_ZERO:  w_we = r_extra || (r_ptr != 6'd56);
            S_LEN: begin
                w_we    = 1'b1;
                w_wbyte = w_len_byte;
            end
            default: w_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) r_buf[r_ptr] <= w_wbyte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_ptr       <= 6'd0;
            r_cnt       <= '0;
            r_final     <= 1'b0;
            r_pend_pad  <= 1'b0;
            r_pend_zero <= 1'b0;
            r_extra     <= 1'b0;
            r_in_msg    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_idx       <= 4'd0;
            r_blk_last  <= 1'b0;
            r_len_ovf   <= 1'b0;
`ifdef SHA256_PADDER_BLKCNT_EN
            r_blk_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        if (in_keep || in_last) begin
                            r_in_msg  <= 1'b1;
                            r_len_ovf <= w_ovf_base | (in_keep & (&r_cnt));
                        end
                        if (in_keep) begin
                            r_ptr <= r_ptr + 6'd1;
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (in_keep && r_ptr == 6'd63) begin
                            r_in_ready <= 1'b0;
                            r_pend_pad <= in_last;
                            r_state    <= S_EMIT;
                        end else if (in_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    r_ptr      <= r_ptr + 6'd1;
                    r_pend_pad <= 1'b0;
                    // Marker in the last byte leaves the block full: flush it before zero fill.
                    if (r_ptr == 6'd63) begin
                        r_pend_zero <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_extra <= (r_ptr >= 6'd56);
                        r_state <= S_ZERO;
                    end
                end
                S_ZERO: begin
                    if (r_extra) begin
                        r_ptr <= r_ptr + 6'd1;
                        if (r_ptr == 6'd63) begin
                            r_extra     <= 1'b0;
                            r_pend_zero <= 1'b1;
                            r_state     <= S_EMIT;
                        end
                    end else if (r_ptr == 6'd56) begin
                        r_state <= S_LEN;
                    end else begin
                        r_ptr <= r_ptr + 6'd1;
                        if (r_ptr == 6'd55) r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    r_ptr <= r_ptr + 6'd1;
                    if (r_ptr == 6'd63) begin
                        r_final <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_word;
                        r_blk_last  <= r_final;
                    end else if (out_ready) begin
                        if (r_idx == 4'd15) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= 32'd0;
                            r_idx       <= 4'd0;
                            r_blk_last  <= 1'b0;
                            if (r_final) begin
                                r_final    <= 1'b0;
                                r_cnt      <= '0;
                                r_ptr      <= 6'd0;
                                r_in_msg   <= 1'b0;
                                r_in_ready <= 1'b1;
                                r_state    <= S_FILL;
`ifdef SHA256_PADDER_BLKCNT_EN
                                r_blk_cnt  <= '0;
`endif
                            end else begin
`ifdef SHA256_PADDER_BLKCNT_EN
                                if (r_blk_cnt != '1) r_blk_cnt <= r_blk_cnt + 1'b1;
`endif
                                if (r_pend_pad) begin
                                    r_state <= S_PAD;
                                end else if (r_pend_zero) begin
                                    r_pend_zero <= 1'b0;
                                    r_state     <= S_ZERO;
                                end else begin
                                    r_in_ready <= 1'b1;
                                    r_state    <= S_FILL;
                                end
                            end
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_out_data <= w_word;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_idx      = r_idx;
    assign out_blk_last = r_blk_last;
    assign len_ovf      = r_len_ovf;
`ifdef SHA256_PADDER_BLKCNT_EN
    assign blk_cnt      = r_blk_cnt;
`endif

endmodule
